// File: rtl/adpcm_multi.sv
// -----------------------------------------------------------------------------
// adpcm_multi -- multi-channel IMA ADPCM encoder/decoder, one conversion at a
// time, serialised over an eight-state FSM (one code bit per cycle).
//
// Each channel owns a 16-bit signed predictor and a 7-bit step index. A
// conversion is requested by toggling req; the selected channel's state is
// read, updated and written back, and done pulses when the results land on
// the tx_* outputs.
//
// Ports
//   clk       rising-edge clock
//   rstn      asynchronous active-low reset
//   enable    1 = run, 0 = synchronous clear of every register and channel
//   req       toggle request; each edge seen while idle starts a conversion
//   ack       high while the FSM is idle
//   done      one-cycle pulse when results are written
//   cst       current FSM state, Gray coded
//   sel_rx    1 = decode rx_adpcm -> tx_pcm, 0 = encode rx_pcm -> tx_adpcm
//   ch_sel    channel for the request (values >= CH map to CH-1)
//   clr       clear state of channel ch_sel; honoured only while idle
//   rx_pcm    signed PCM sample (encode)
//   rx_adpcm  ADPCM nibble (decode), bit 3 = sign
//   tx_pcm    decoded sample (updated on decode only)
//   tx_adpcm  encoded nibble (updated on encode only)
//   tx_idx    post-update step index of the served channel
//   tx_ch     channel of the last completed conversion
// -----------------------------------------------------------------------------
module adpcm_multi #(
  parameter int CH  = 2,
  parameter int CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  req,
  output logic                  ack,
  output logic                  done,
  output logic [2:0]            cst,
  input  logic                  sel_rx,
  input  logic [CHW-1:0]        ch_sel,
  input  logic                  clr,
  input  logic signed [15:0]    rx_pcm,
  input  logic [3:0]            rx_adpcm,
  output logic signed [15:0]    tx_pcm,
  output logic [3:0]            tx_adpcm,
  output logic [6:0]            tx_idx,
  output logic [CHW-1:0]        tx_ch
);

  // Gray-coded sequence: consecutive states differ in one bit.
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    LOAD   = 3'b001,
    B3     = 3'b011,
    B2     = 3'b010,
    B1     = 3'b110,
    B0     = 3'b111,
    UPDATE = 3'b101,
    STEP   = 3'b100
  } state_t;

  // IMA ADPCM quantiser step sizes, indexed by step index 0..88.
  localparam logic [15:0] STEP_TAB [89] = '{
    16'd7,     16'd8,     16'd9,     16'd10,    16'd11,    16'd12,    16'd13,    16'd14,
    16'd16,    16'd17,    16'd19,    16'd21,    16'd23,    16'd25,    16'd28,    16'd31,
    16'd34,    16'd37,    16'd41,    16'd45,    16'd50,    16'd55,    16'd60,    16'd66,
    16'd73,    16'd80,    16'd88,    16'd97,    16'd107,   16'd118,   16'd130,   16'd143,
    16'd157,   16'd173,   16'd190,   16'd209,   16'd230,   16'd253,   16'd279,   16'd307,
    16'd337,   16'd371,   16'd408,   16'd449,   16'd494,   16'd544,   16'd598,   16'd658,
    16'd724,   16'd796,   16'd876,   16'd963,   16'd1060,  16'd1166,  16'd1282,  16'd1411,
    16'd1552,  16'd1707,  16'd1878,  16'd2066,  16'd2272,  16'd2499,  16'd2749,  16'd3024,
    16'd3327,  16'd3660,  16'd4026,  16'd4428,  16'd4871,  16'd5358,  16'd5894,  16'd6484,
    16'd7132,  16'd7845,  16'd8630,  16'd9493,  16'd10442, 16'd11487, 16'd12635, 16'd13899,
    16'd15289, 16'd16818, 16'd18500, 16'd20350, 16'd22385, 16'd24623, 16'd27086, 16'd29794,
    16'd32767
  };

  state_t state, state_nxt;
  logic   req_d;
  logic   req_edge;

  // Request fields captured on IDLE->LOAD.
  logic                 sel_q;
  logic [CHW-1:0]       ch_q;
  logic signed [15:0]   pcm_q;
  logic [3:0]           adpcm_q;

  // Working registers of the conversion in flight.
  logic                 sign_q;
  logic [2:0]           code_q;
  logic [16:0]          diff_q;     // |rx_pcm - predict|, up to 65535
  logic [15:0]          step_q;
  logic [16:0]          vpdiff_q;   // at most 1.875 * 32767
  logic signed [15:0]   pred_q;
  logic [6:0]           idx_q;

  // Per-channel codec state.
  logic signed [15:0]   ch_pred [CH];
  logic [6:0]           ch_idx  [CH];

  // Combinational helpers.
  logic [CHW-1:0]       ch_map;
  logic signed [15:0]   cur_pred;
  logic [6:0]           cur_idx;
  logic [15:0]          cur_step;
  logic [16:0]          enc_diff;
  logic [16:0]          enc_mag;
  logic [1:0]           bit_pos;
  logic                 take;
  logic signed [17:0]   pred_ext;
  logic signed [17:0]   vp_ext;
  logic signed [17:0]   pred_sum;
  logic signed [15:0]   pred_new;
  logic signed [7:0]    idx_adj;
  logic signed [7:0]    idx_sum;
  logic [6:0]           idx_new;

  assign ack      = (state == IDLE);
  assign cst      = state;
  assign req_edge = (state == IDLE) && (req ^ req_d);

  // Out-of-range channel numbers fold onto the last channel.
  always_comb begin
    ch_map = ch_sel;
    if (int'(ch_sel) >= CH) ch_map = CHW'(CH - 1);
  end

  assign cur_pred = ch_pred[ch_q];
  assign cur_idx  = ch_idx[ch_q];
  assign cur_step = STEP_TAB[cur_idx];

  // 17-bit two's-complement difference; bit 16 is the sign.
  assign enc_diff = {pcm_q[15], pcm_q} - {cur_pred[15], cur_pred};
  assign enc_mag  = enc_diff[16] ? (~enc_diff + 17'd1) : enc_diff;

  // NOTE: every signal written in an always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    bit_pos = 2'd0;
    if (state == B2)      bit_pos = 2'd2;
    else if (state == B1) bit_pos = 2'd1;
    take = sel_q ? adpcm_q[bit_pos] : (diff_q >= {1'b0, step_q});
  end

  // Predictor update is done 18 bits wide: predict + 61436 would wrap at 17.
  always_comb begin
    pred_ext = {{2{pred_q[15]}}, pred_q};
    vp_ext   = {1'b0, vpdiff_q};
    pred_sum = sign_q ? (pred_ext - vp_ext) : (pred_ext + vp_ext);
    pred_new = pred_sum[15:0];
    if (pred_sum > 18'sd32767)       pred_new = 16'sh7FFF;
    else if (pred_sum < -18'sd32768) pred_new = 16'sh8000;

    // Index step: -1 for codes 0..3, then 2,4,6,8 for codes 4..7.
    idx_adj = -8'sd1;
    if (code_q[2]) idx_adj = $signed({5'd0, code_q[1:0], 1'b0}) + 8'sd2;
    idx_sum = $signed({1'b0, idx_q}) + idx_adj;
    idx_new = idx_sum[6:0];
    if (idx_sum < 8'sd0)       idx_new = 7'd0;
    else if (idx_sum > 8'sd88) idx_new = 7'd88;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_edge) state_nxt = LOAD;
      LOAD:    state_nxt = B3;
      B3:      state_nxt = B2;
      B2:      state_nxt = B1;
      B1:      state_nxt = B0;
      B0:      state_nxt = UPDATE;
      UPDATE:  state_nxt = STEP;
      STEP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      req_d <= 1'b0;
    end else if (!enable) begin
      state <= IDLE;
      req_d <= 1'b0;
    end else begin
      state <= state_nxt;
      req_d <= req;
    end
  end

  // NOTE: the channel state arrays are reset like ordinary flops; they are
  // small and must read as zero after reset or enable low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CH; i++) begin
        ch_pred[i] <= '0;
        ch_idx[i]  <= '0;
      end
    end else if (!enable) begin
      for (int i = 0; i < CH; i++) begin
        ch_pred[i] <= '0;
        ch_idx[i]  <= '0;
      end
    end else if (state == IDLE && clr) begin
      // Cleared before LOAD reads it, so a same-cycle request starts from zero.
      ch_pred[ch_map] <= '0;
      ch_idx[ch_map]  <= '0;
    end else if (state == STEP) begin
      ch_pred[ch_q] <= pred_q;
      ch_idx[ch_q]  <= idx_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_q    <= 1'b0;
      ch_q     <= '0;
      pcm_q    <= '0;
      adpcm_q  <= '0;
      sign_q   <= 1'b0;
      code_q   <= '0;
      diff_q   <= '0;
      step_q   <= '0;
      vpdiff_q <= '0;
      pred_q   <= '0;
      idx_q    <= '0;
      done     <= 1'b0;
      tx_pcm   <= '0;
      tx_adpcm <= '0;
      tx_idx   <= '0;
      tx_ch    <= '0;
    end else if (!enable) begin
      sel_q    <= 1'b0;
      ch_q     <= '0;
      pcm_q    <= '0;
      adpcm_q  <= '0;
      sign_q   <= 1'b0;
      code_q   <= '0;
      diff_q   <= '0;
      step_q   <= '0;
      vpdiff_q <= '0;
      pred_q   <= '0;
      idx_q    <= '0;
      done     <= 1'b0;
      tx_pcm   <= '0;
      tx_adpcm <= '0;
      tx_idx   <= '0;
      tx_ch    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_edge) begin
            sel_q   <= sel_rx;
            ch_q    <= ch_map;
            pcm_q   <= rx_pcm;
            adpcm_q <= rx_adpcm;
          end
        end
        LOAD: begin
          step_q   <= cur_step;
          vpdiff_q <= {4'd0, cur_step[15:3]};
          pred_q   <= cur_pred;
          idx_q    <= cur_idx;
          code_q   <= '0;
          if (sel_q) begin
            sign_q <= adpcm_q[3];
            diff_q <= '0;
          end else begin
            sign_q <= enc_diff[16];
            diff_q <= enc_mag;
          end
        end
        B2, B1, B0: begin
          if (take) begin
            code_q[bit_pos] <= 1'b1;
            vpdiff_q        <= vpdiff_q + {1'b0, step_q};
            if (!sel_q) diff_q <= diff_q - {1'b0, step_q};
          end
          step_q <= step_q >> 1;
        end
        UPDATE: begin
          pred_q <= pred_new;
          idx_q  <= idx_new;
        end
        STEP: begin
          if (sel_q) tx_pcm   <= pred_q;
          else       tx_adpcm <= {sign_q, code_q};
          tx_idx <= idx_q;
          tx_ch  <= ch_q;
          done   <= 1'b1;
        end
        default: ;  // B3: the sign bit was settled in LOAD
      endcase
    end
  end

endmodule

// File: tb/tb_adpcm_multi.sv
// -----------------------------------------------------------------------------
// tb_adpcm_multi -- directed bench for adpcm_multi (CH=3).
// A transaction-level IMA ADPCM model computes each conversion's result when
// the request is accepted and releases it seven edges later; one compare
// process checks ack/cst/done/tx_* against it on every falling edge. Literal
// expectations pin the model on the hand-computed vectors.
// -----------------------------------------------------------------------------
module tb_adpcm_multi;
  localparam int CH  = 3;
  localparam int CHW = 2;

  logic                clk = 1'b0;
  logic                rstn, enable, req, ack, done, sel_rx, clr;
  logic [2:0]          cst;
  logic [CHW-1:0]      ch_sel, tx_ch;
  logic signed [15:0]  rx_pcm, tx_pcm;
  logic [3:0]          rx_adpcm, tx_adpcm;
  logic [6:0]          tx_idx;

  int checks   = 0;
  int failures = 0;

  adpcm_multi #(.CH(CH), .CHW(CHW)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .req(req), .ack(ack),
    .done(done), .cst(cst), .sel_rx(sel_rx), .ch_sel(ch_sel), .clr(clr),
    .rx_pcm(rx_pcm), .rx_adpcm(rx_adpcm), .tx_pcm(tx_pcm),
    .tx_adpcm(tx_adpcm), .tx_idx(tx_idx), .tx_ch(tx_ch)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int step_tab [89] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
    19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
    130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
    337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
    876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
    2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
    5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
  };
  int idx_step [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

  int   m_pred [CH];
  int   m_idx  [CH];
  int   m_phase;            // 0 = idle, 1..7 = cycles since acceptance
  logic m_reqd;
  int   p_ch, p_pred, p_idx, p_code;
  bit   p_dec;
  int   e_pcm, e_adpcm, e_idx, e_ch;
  bit   e_done;

  function automatic void ref_conv(input bit dec, input int pcm, input logic [3:0] nib,
                                   input int pred_in, input int idx_in,
                                   output int pred_out, output int idx_out, output int code4);
    int step, vp, diff, code;
    bit neg;
    step = step_tab[idx_in];
    vp   = step / 8;
    code = 0;
    if (dec) begin
      neg  = nib[3];
      diff = 0;
    end else begin
      diff = pcm - pred_in;
      neg  = diff < 0;
      if (neg) diff = -diff;
    end
    for (int b = 2; b >= 0; b--) begin
      if (dec ? nib[b] : (diff >= step)) begin
        code += (1 << b);
        diff -= step;
        vp   += step;
      end
      step = step / 2;
    end
    pred_out = neg ? pred_in - vp : pred_in + vp;
    if (pred_out > 32767)  pred_out = 32767;
    if (pred_out < -32768) pred_out = -32768;
    idx_out = idx_in + idx_step[code];
    if (idx_out < 0)  idx_out = 0;
    if (idx_out > 88) idx_out = 88;
    code4 = (neg ? 8 : 0) + code;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < CH; i++) begin
      m_pred[i] = 0;
      m_idx[i]  = 0;
    end
    m_phase = 0; m_reqd = 1'b0; e_done = 1'b0;
    e_pcm = 0; e_adpcm = 0; e_idx = 0; e_ch = 0;
  endfunction

  always @(posedge clk or negedge rstn) begin
    int mch;
    if (!rstn) model_clear();
    else if (!enable) model_clear();
    else begin
      e_done = 1'b0;
      if (m_phase == 0) begin
        mch = (int'(ch_sel) >= CH) ? CH - 1 : int'(ch_sel);
        if (clr) begin
          m_pred[mch] = 0;
          m_idx[mch]  = 0;
        end
        if (req !== m_reqd) begin
          ref_conv(sel_rx, int'(rx_pcm), rx_adpcm, m_pred[mch], m_idx[mch],
                   p_pred, p_idx, p_code);
          p_ch    = mch;
          p_dec   = sel_rx;
          m_phase = 1;
        end
      end else if (m_phase == 7) begin
        m_pred[p_ch] = p_pred;
        m_idx[p_ch]  = p_idx;
        if (p_dec) e_pcm = p_pred;
        else       e_adpcm = p_code;
        e_idx   = p_idx;
        e_ch    = p_ch;
        e_done  = 1'b1;
        m_phase = 0;
      end else begin
        m_phase++;
      end
      m_reqd = req;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("ack",      ack,      m_phase == 0);
    check("cst",      cst,      m_phase ^ (m_phase >> 1));
    check("done",     done,     e_done);
    check("tx_pcm",   tx_pcm,   e_pcm);
    check("tx_adpcm", tx_adpcm, e_adpcm);
    check("tx_idx",   tx_idx,   e_idx);
    check("tx_ch",    tx_ch,    e_ch);
  end

  // ---------------- stimulus ----------------
  task automatic start(input bit dec, input int ch, input int pcm,
                       input logic [3:0] nib, input bit with_clr);
    @(negedge clk); #1;
    sel_rx   = dec;
    ch_sel   = CHW'(ch);
    rx_pcm   = 16'(pcm);
    rx_adpcm = nib;
    clr      = with_clr;
    req      = ~req;
  endtask

  // Counts falling edges until done; 99 means it never came.
  task automatic wait_done(output int lat);
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      if (n == 1) begin
        #1 clr = 1'b0;
      end
    end
  endtask

  // done is high on the 8th falling edge after the toggle.
  task automatic conv(input bit dec, input int ch, input int pcm,
                      input logic [3:0] nib, input bit with_clr);
    int lat;
    start(dec, ch, pcm, nib, with_clr);
    wait_done(lat);
    check("latency", lat, 8);
  endtask

  initial begin
    int lat, cnt, prev;
    bit found;
    rstn = 1'b1; enable = 1'b1; req = 1'b0; sel_rx = 1'b0; ch_sel = '0;
    clr = 1'b0; rx_pcm = '0; rx_adpcm = '0;
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack", ack, 1);
    check("rst_cst", cst, 0);
    check("rst_done", done, 0);
    check("rst_tx_pcm", tx_pcm, 0);
    check("rst_tx_idx", tx_idx, 0);
    #1 rstn = 1'b1;

    // Encode ch0 from zero state.
    conv(0, 0, 1000, 4'h0, 0);
    check("enc0_code", tx_adpcm, 7);
    check("enc0_idx", tx_idx, 8);
    check("enc0_ch", tx_ch, 0);
    check("model_pred0", m_pred[0], 11);

    // Decode ch1; ch0 must keep its state, tx_adpcm must hold.
    conv(1, 1, 0, 4'hF, 0);
    check("dec1_pcm", tx_pcm, -11);
    check("dec1_idx", tx_idx, 8);
    check("dec1_ch", tx_ch, 1);
    check("dec1_adpcm_hold", tx_adpcm, 7);

    // Second encode on ch0 continues from predict=11, idx=8.
    conv(0, 0, 1000, 4'h0, 0);
    check("enc0b_code", tx_adpcm, 7);
    check("enc0b_idx", tx_idx, 16);
    check("enc0b_pcm_hold", tx_pcm, -11);
    check("model_pred0b", m_pred[0], 41);

    // Zero nibble at idx 0: nothing moves.
    conv(1, 2, 0, 4'h0, 0);
    check("dec0_pcm", tx_pcm, 0);
    check("dec0_idx", tx_idx, 0);
    check("dec0_ch", tx_ch, 2);

    // Out-of-range channel folds onto ch2.
    conv(1, 3, 0, 4'hF, 0);
    check("fold_ch", tx_ch, 2);
    check("fold_pcm", tx_pcm, -11);
    check("fold_idx", tx_idx, 8);

    // clr with request in the same cycle: ch0 restarts from zero.
    conv(0, 0, 1000, 4'h0, 1);
    check("clr_code", tx_adpcm, 7);
    check("clr_idx", tx_idx, 8);

    // Extremes, checked by the model.
    conv(0, 1, -20000, 4'h0, 0);
    conv(0, 2, 32767, 4'h0, 0);
    conv(0, 0, -32768, 4'h0, 0);
    conv(1, 2, 0, 4'h8, 0);

    // Repeated +7 decode: monotonic rise into saturation.
    prev = -40000;
    for (int i = 0; i < 24; i++) begin
      conv(1, 1, 0, 4'h7, 0);
      check("sat_rise", (int'(tx_pcm) > prev) || (tx_pcm == 16'sh7FFF), 1);
      prev = int'(tx_pcm);
    end
    check("sat_pcm", tx_pcm, 32767);
    check("sat_idx", tx_idx, 88);

    // A second toggle during a conversion is lost: exactly one done.
    start(0, 2, 500, 4'h0, 0);
    cnt = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (done) cnt++;
      if (n == 2) begin
        #1 req = ~req;
      end
    end
    check("one_done", cnt, 1);

    // enable low mid-conversion clears everything.
    start(0, 0, 1000, 4'h0, 0);
    repeat (3) @(negedge clk);
    #1 enable = 1'b0; req = 1'b0;
    @(negedge clk);
    check("en_ack", ack, 1);
    check("en_cst", cst, 0);
    check("en_tx_adpcm", tx_adpcm, 0);
    check("en_tx_idx", tx_idx, 0);
    #1 enable = 1'b1;
    conv(0, 0, 1000, 4'h0, 0);
    check("en_code", tx_adpcm, 7);
    check("en_idx", tx_idx, 8);

    // Reset during B1, then a request pending at release.
    start(1, 1, 0, 4'h7, 0);
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (cst == 3'b110) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_b1", found, 1);
    #1 rstn = 1'b0;
    @(negedge clk);
    check("rb1_ack", ack, 1);
    check("rb1_tx_pcm", tx_pcm, 0);
    check("rb1_tx_adpcm", tx_adpcm, 0);
    check("rb1_tx_idx", tx_idx, 0);
    check("rb1_tx_ch", tx_ch, 0);
    #1;
    sel_rx = 1'b0; ch_sel = '0; rx_pcm = 16'sd1000; req = 1'b1;
    rstn = 1'b1;
    wait_done(lat);
    check("rel_latency", lat, 8);
    check("rel_code", tx_adpcm, 7);
    check("rel_idx", tx_idx, 8);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
